// File: rtl/vc_out_arbiter.sv
// Output arbiter for a NoC port: picks one VC buffer at a time, holds the grant
// for a whole packet (head..tail), and forwards flits through one output register.
module vc_out_arbiter #(
  parameter int NUM_VC     = 4,
  parameter int FLIT_WIDTH = 34
) (
  input  logic                         clk,
  input  logic                         arst,
  input  logic [NUM_VC*FLIT_WIDTH-1:0] fdata_i,
  input  logic [NUM_VC-1:0]            valid_i,
  output logic [NUM_VC-1:0]            ready_o,
  output logic [FLIT_WIDTH-1:0]        fdata_o,
  output logic [1:0]                   vc_id_o,
  output logic                         valid_o,
  input  logic                         ready_i,
  output logic [15:0]                  pkt_cnt_o,
  output logic                         err_o
);

  typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

  localparam logic [1:0] FT_HEAD = 2'b00;
  localparam logic [1:0] FT_TAIL = 2'b11;

  state_t                  r_state, w_state_nxt;
  logic [1:0]              r_rr_ptr, w_rr_ptr_nxt;
  logic [1:0]              r_lock_vc, w_lock_vc_nxt;
  logic [1:0]              w_gnt;
  logic                    w_gnt_vld;
  logic                    w_out_free;
  logic                    w_xfer;
  logic                    w_err_set;
  logic [FLIT_WIDTH-1:0]   w_flit;
  logic [1:0]              w_ftype;
  logic [NUM_VC-1:0]       w_ready;

  logic [FLIT_WIDTH-1:0]   r_fdata;
  logic [1:0]              r_vc_id;
  logic                    r_valid;
  logic [15:0]             r_pkt_cnt;
  logic                    r_err;

  function automatic logic [1:0] inc_mod(input logic [1:0] v);
    if (int'(v) >= NUM_VC - 1) return 2'd0;
    return v + 2'd1;
  endfunction

  assign w_out_free = !r_valid || ready_i;

  // Grant selection: the lock owner, or first valid VC at/after rr_ptr
  always_comb begin
    w_gnt     = '0;
    w_gnt_vld = 1'b0;
    if (r_state == ST_LOCKED) begin
      w_gnt = r_lock_vc;
      for (int k = 0; k < NUM_VC; k++) begin
        if (2'(k) == r_lock_vc) w_gnt_vld = valid_i[k];
      end
    end else begin
      // Descending offset so the nearest VC to rr_ptr is the last one written
      for (int i = NUM_VC - 1; i >= 0; i--) begin
        for (int k = 0; k < NUM_VC; k++) begin
          if (valid_i[k] && k == ((int'(r_rr_ptr) + i) % NUM_VC)) begin
            w_gnt     = 2'(k);
            w_gnt_vld = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    w_flit = '0;
    for (int k = 0; k < NUM_VC; k++) begin
      if (2'(k) == w_gnt) w_flit = fdata_i[k*FLIT_WIDTH +: FLIT_WIDTH];
    end
  end

  assign w_ftype = w_flit[FLIT_WIDTH-1 -: 2];
  assign w_xfer  = w_gnt_vld && w_out_free && arst;

  always_comb begin
    w_ready = '0;
    for (int k = 0; k < NUM_VC; k++) begin
      w_ready[k] = w_xfer && (2'(k) == w_gnt);
    end
  end

  assign ready_o = w_ready;

  always_comb begin
    w_state_nxt   = r_state;
    w_rr_ptr_nxt  = r_rr_ptr;
    w_lock_vc_nxt = r_lock_vc;
    w_err_set     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_xfer) begin
          if (w_ftype == FT_HEAD) begin
            w_state_nxt   = ST_LOCKED;
            w_lock_vc_nxt = w_gnt;
          end else begin
            w_err_set    = 1'b1;
            w_rr_ptr_nxt = inc_mod(w_gnt);
          end
        end
      end
      ST_LOCKED: begin
        if (w_xfer) begin
          if (w_ftype == FT_TAIL) begin
            w_state_nxt  = ST_IDLE;
            w_rr_ptr_nxt = inc_mod(r_lock_vc);
          end else if (w_ftype == FT_HEAD) begin
            w_err_set = 1'b1;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!arst) begin
      r_state   <= ST_IDLE;
      r_rr_ptr  <= '0;
      r_lock_vc <= '0;
      r_valid   <= 1'b0;
      r_fdata   <= '0;
      r_vc_id   <= '0;
      r_pkt_cnt <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_rr_ptr  <= w_rr_ptr_nxt;
      r_lock_vc <= w_lock_vc_nxt;
      if (w_out_free) begin
        r_valid <= w_xfer;
        if (w_xfer) begin
          r_fdata <= w_flit;
          r_vc_id <= w_gnt;
        end
      end
      if (r_valid && ready_i && r_fdata[FLIT_WIDTH-1 -: 2] == FT_TAIL)
        r_pkt_cnt <= r_pkt_cnt + 16'd1;
      if (w_err_set) r_err <= 1'b1;
    end
  end

  assign fdata_o   = r_fdata;
  assign vc_id_o   = r_vc_id;
  assign valid_o   = r_valid;
  assign pkt_cnt_o = r_pkt_cnt;
  assign err_o     = r_err;

endmodule

// File: doc/vc_out_arbiter.md
VC_OUT_ARBITER -- requirements
Module: vc_out_arbiter

Interface
REQ-001 SHALL have parameter NUM_VC, default 4, the number of VC buffers feeding the block (2..4).
REQ-002 SHALL have parameter FLIT_WIDTH, default 34, the flit width; bits [FLIT_WIDTH-1:FLIT_WIDTH-2] are the flit type.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port arst  input  1  reset, synchronous, active-low (sampled on clk rising edge only).
REQ-005 SHALL have port fdata_i  input  NUM_VC*FLIT_WIDTH  flits from the VC buffers; VC k occupies slice [k*FLIT_WIDTH +: FLIT_WIDTH].
REQ-006 SHALL have port valid_i  input  NUM_VC  per-VC flit-valid from the VC buffers (their valid_o).
REQ-007 SHALL have port ready_o  output  NUM_VC  per-VC accept, driving the VC buffers' ready_i.
REQ-008 SHALL have port fdata_o  output  FLIT_WIDTH  registered output flit.
REQ-009 SHALL have port vc_id_o  output  2  VC index of the flit on fdata_o.
REQ-010 SHALL have port valid_o  output  1  fdata_o/vc_id_o valid.
REQ-011 SHALL have port ready_i  input  1  downstream accept.
REQ-012 SHALL have port pkt_cnt_o  output  16  count of tail flits forwarded downstream.
REQ-013 SHALL have port err_o  output  1  sticky protocol-error flag.

Function
REQ-014 SHALL decode flit type as: 2'b00 head, 2'b01 body, 2'b11 tail, 2'b10 reserved (treated as body).
REQ-015 SHALL implement a two-state FSM: IDLE (no packet owns the output) and LOCKED (output owned by lock_vc until its tail is accepted).
REQ-016 SHALL define out_free = !valid_o | ready_i; no input flit is accepted in a cycle where out_free is 0.
REQ-017 In IDLE, SHALL grant the first VC with valid_i set, searching from rr_ptr upward modulo NUM_VC; grant is combinational in the same cycle.
REQ-018 In LOCKED, SHALL grant only lock_vc; valid_i of other VCs is ignored.
REQ-019 SHALL assert ready_o[g] only for the granted VC g, and only when valid_i[g] and out_free; at most one ready_o bit is high per cycle.
REQ-020 An input transfer occurs when valid_i[g] & ready_o[g]; the flit and g SHALL appear on fdata_o/vc_id_o with valid_o=1 on the next cycle (latency 1).
REQ-021 When out_free=1 and no transfer occurs, valid_o SHALL go 0 next cycle; when out_free=0, fdata_o/vc_id_o/valid_o SHALL hold.
REQ-022 IDLE -> LOCKED on transfer of a head flit; lock_vc <= granted VC.
REQ-023 LOCKED -> IDLE on transfer of a tail flit from lock_vc; rr_ptr <= (lock_vc+1) mod NUM_VC.
REQ-024 A transfer in IDLE of a non-head flit SHALL be forwarded, SHALL set err_o, SHALL leave state IDLE and set rr_ptr <= (granted+1) mod NUM_VC.
REQ-025 A head flit transferred in LOCKED SHALL be forwarded, SHALL set err_o, and the lock SHALL be kept.
REQ-026 pkt_cnt_o SHALL increment by 1 in the cycle a flit with tail type is accepted downstream (valid_o & ready_i), wrapping 16'hFFFF -> 0.
REQ-027 err_o SHALL stay set until reset.

Reset
REQ-028 While arst=0 at a clk edge: state<=IDLE, rr_ptr<=0, lock_vc<=0, valid_o<=0, fdata_o<=0, vc_id_o<=0, pkt_cnt_o<=0, err_o<=0.
REQ-029 ready_o SHALL be all-zero in any cycle where arst=0, including reset asserted mid-packet; the partial packet is abandoned.

Verification
REQ-030 After reset, valid_i=4'b0101, both head flits, ready_i=1 -> VC0 granted first, vc_id_o=0 next cycle; VC2 blocked until VC0 tail accepted.
REQ-031 VC1 sends head/body/tail, ready_i held 0 for 3 cycles after first flit -> ready_o[1]=0 during stall, flits emerge in order unduplicated, pkt_cnt_o=1.
REQ-032 All 4 VCs continuously send 1-head+1-tail packets, ready_i=1 -> grants rotate 0,1,2,3,0; no VC starved; pkt_cnt_o increments once per packet.
REQ-033 Tail flit on VC3 in IDLE -> flit forwarded with vc_id_o=3, err_o=1, state remains IDLE.
REQ-034 arst=0 for one cycle while LOCKED on VC2 with valid_o=1 -> next cycle valid_o=0, pkt_cnt_o=0, err_o=0, new head on VC0 granted.
REQ-035 Preload pkt_cnt_o at 16'hFFFF via 65535 packets, send one more packet -> pkt_cnt_o=0.
